// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweep controller.
// Optional compare logic elsewhere is enabled by the macro TT_SWEEP_COMPARE_EN.
package tt_sweep_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StDrive = ST_DRIVE,
        StDone  = ST_DONE
    } state_e;

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// Bus between the sweep controller (master) and the function-under-test side (slave).
// Defining TT_SWEEP_COMPARE_EN adds exp_tt, mismatch and first_err.
interface tt_sweep_ctrl_if #(
    parameter int unsigned N_IN = 4
) ();

    localparam int unsigned NVEC = 1 << N_IN;

    logic            start;
    logic            abort;
    logic            f;
    logic [N_IN-1:0] vec;
    logic            vec_valid;
    logic [NVEC-1:0] tt;
    logic [N_IN:0]   ones_cnt;
    logic            busy;
    logic            done;
`ifdef TT_SWEEP_COMPARE_EN
    logic [NVEC-1:0] exp_tt;
    logic            mismatch;
    logic [N_IN-1:0] first_err;
`endif

    modport master (
`ifdef TT_SWEEP_COMPARE_EN
        input  exp_tt,
        output mismatch,
        output first_err,
`endif
        input  start,
        input  abort,
        input  f,
        output vec,
        output vec_valid,
        output tt,
        output ones_cnt,
        output busy,
        output done
    );

    modport slave (
`ifdef TT_SWEEP_COMPARE_EN
        output exp_tt,
        input  mismatch,
        input  first_err,
`endif
        output start,
        output abort,
        output f,
        input  vec,
        input  vec_valid,
        input  tt,
        input  ones_cnt,
        input  busy,
        input  done
    );

endinterface

// File: rtl/tt_sweep_cnt.sv
// Vector index and dwell counter pair: each index is held SETTLE+1 enabled cycles,
// and the index stops at the terminal value instead of wrapping.
module tt_sweep_cnt
    import tt_sweep_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    output logic [N_IN-1:0]     vec,
    output logic [SETTLE_W-1:0] dwell,
    output logic                sample,
    output logic                last
);

    assign sample = en && (dwell == SETTLE_W'(SETTLE));
    assign last   = (vec == {N_IN{1'b1}});

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vec   <= '0;
            dwell <= '0;
        end else if (en) begin
            if (sample) begin
                dwell <= '0;
                if (!last) begin
                    vec <= vec + 1'b1;
                end
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: drives all 2**N_IN input vectors, captures f and counts ones.
// Optional expected-table compare is enabled by the macro TT_SWEEP_COMPARE_EN.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input logic           clk,
    input logic           rst,
    tt_sweep_ctrl_if.master bus
);

    localparam int unsigned NVEC = 1 << N_IN;

    state_e                state_q;
    logic [NVEC-1:0]       tt_q;
    logic [N_IN:0]         ones_q;
    logic                  busy_q;
    logic                  vec_valid_q;
    logic                  done_q;
`ifdef TT_SWEEP_COMPARE_EN
    logic                  mismatch_q;
    logic [N_IN-1:0]       first_err_q;
`endif

    logic                  accept;
    logic                  cnt_en;
    logic [N_IN-1:0]       vec;
    logic [SETTLE_W-1:0]   dwell;
    logic                  sample;
    logic                  last;

    assign accept = (state_q == StIdle) && bus.start && !bus.abort;
    // Abort freezes the counter so vec holds where the sweep stopped.
    assign cnt_en = (state_q == StDrive) && !bus.abort;

    tt_sweep_cnt #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (cnt_en),
        .vec    (vec),
        .dwell  (dwell),
        .sample (sample),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tt_q        <= '0;
            ones_q      <= '0;
            busy_q      <= 1'b0;
            vec_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef TT_SWEEP_COMPARE_EN
            mismatch_q  <= 1'b0;
            first_err_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q     <= StDrive;
                        tt_q        <= '0;
                        ones_q      <= '0;
                        busy_q      <= 1'b1;
                        vec_valid_q <= 1'b1;
`ifdef TT_SWEEP_COMPARE_EN
                        mismatch_q  <= 1'b0;
                        first_err_q <= '0;
`endif
                    end
                end
                StDrive: begin
                    if (bus.abort) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        vec_valid_q <= 1'b0;
                    end else if (sample) begin
                        tt_q[vec] <= bus.f;
                        ones_q    <= ones_q + (N_IN + 1)'(bus.f);
`ifdef TT_SWEEP_COMPARE_EN
                        if ((bus.f != bus.exp_tt[vec]) && !mismatch_q) begin
                            mismatch_q  <= 1'b1;
                            first_err_q <= vec;
                        end
`endif
                        if (last) begin
                            state_q     <= StDone;
                            busy_q      <= 1'b0;
                            vec_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q     <= StIdle;
                    busy_q      <= 1'b0;
                    vec_valid_q <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vec       = vec;
    assign bus.vec_valid = vec_valid_q;
    assign bus.tt        = tt_q;
    assign bus.ones_cnt  = ones_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef TT_SWEEP_COMPARE_EN
    assign bus.mismatch  = mismatch_q;
    assign bus.first_err = first_err_q;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: three instances (SETTLE = 1, 0, 3), directed and random sweeps
// against a table-level model. Compare checks are active when TT_SWEEP_COMPARE_EN is defined.
module tb_tt_sweep_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        start_v [3];
    logic        abort_v [3];
    logic [15:0] fn_v    [3];
    logic [15:0] exp_v   [3];
    logic [15:0] tt_o    [3];
    logic [4:0]  ones_o  [3];
    logic [3:0]  vec_o   [3];
    logic        busy_o  [3];
    logic        done_o  [3];
    logic        vv_o    [3];
    logic        mm_o    [3];
    logic [3:0]  fe_o    [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tt_sweep_ctrl_if #(.N_IN(4)) bus ();
        tt_sweep_ctrl #(
            .N_IN   (4),
            .SETTLE ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign bus.start = start_v[g];
        assign bus.abort = abort_v[g];
        assign bus.f     = fn_v[g][bus.vec];
        assign tt_o[g]   = bus.tt;
        assign ones_o[g] = bus.ones_cnt;
        assign vec_o[g]  = bus.vec;
        assign busy_o[g] = bus.busy;
        assign done_o[g] = bus.done;
        assign vv_o[g]   = bus.vec_valid;
`ifdef TT_SWEEP_COMPARE_EN
        assign bus.exp_tt = exp_v[g];
        assign mm_o[g]    = bus.mismatch;
        assign fe_o[g]    = bus.first_err;
`else
        assign mm_o[g]    = 1'b0;
        assign fe_o[g]    = 4'd0;
`endif
    end

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    // f2 = (~c&d)|(a&~c)|(a&~b)|(~a&b&d), vec = {a,b,c,d}
    function automatic logic [15:0] f2_table();
        logic [15:0] t;
        logic [3:0]  v;
        for (int k = 0; k < 16; k++) begin
            v    = 4'(k);
            t[k] = (~v[1] & v[0]) | (v[3] & ~v[1]) | (v[3] & ~v[2]) | (~v[3] & v[2] & v[0]);
        end
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sweep on instance d; abort_at = cycle of DRIVE (1-based) whose closing edge sees abort,
    // 0 = run to completion. Expectations come from the table fn and the hold length only.
    task automatic sweep(input int d, input logic [15:0] fn, input logic [15:0] exp,
                         input int abort_at, input bit poke, input string tag);
        int          s;
        int          len;
        int          n;
        logic [31:0] m;
        logic [15:0] want_tt;
        int          want_ones;
        bit          want_mm;
        int          want_fe;
        s         = settle_of(d);
        len       = 16 * (s + 1);
        n         = (abort_at != 0) ? (abort_at - 1) / (s + 1) : 16;
        m         = (32'd1 << n) - 32'd1;
        want_tt   = fn & m[15:0];
        want_ones = $countones(want_tt);
        want_mm   = 1'b0;
        want_fe   = 0;
        for (int k = 0; k < n; k++) begin
            if (fn[k] != exp[k] && !want_mm) begin
                want_mm = 1'b1;
                want_fe = k;
            end
        end
        fn_v[d]    = fn;
        exp_v[d]   = exp;
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        chk({tag, "_clr_tt"}, tt_o[d], 0);
        chk({tag, "_clr_ones"}, ones_o[d], 0);
        for (int c = 1; c <= len; c++) begin
            chk({tag, "_busy"}, busy_o[d], 1);
            chk({tag, "_vv"}, vv_o[d], 1);
            chk({tag, "_vec"}, vec_o[d], (c - 1) / (s + 1));
            chk({tag, "_nodone"}, done_o[d], 0);
            if (c == abort_at) begin
                abort_v[d] = 1'b1;
                start_v[d] = 1'b0;
                tick();
                abort_v[d] = 1'b0;
                chk({tag, "_ab_busy"}, busy_o[d], 0);
                chk({tag, "_ab_vv"}, vv_o[d], 0);
                chk({tag, "_ab_vec"}, vec_o[d], (c - 1) / (s + 1));
                chk({tag, "_ab_tt"}, tt_o[d], want_tt);
                chk({tag, "_ab_ones"}, ones_o[d], want_ones);
`ifdef TT_SWEEP_COMPARE_EN
                chk({tag, "_ab_mm"}, mm_o[d], want_mm);
                chk({tag, "_ab_fe"}, fe_o[d], want_fe);
`endif
                chk({tag, "_ab_done0"}, done_o[d], 0);
                tick();
                chk({tag, "_ab_done1"}, done_o[d], 0);
                chk({tag, "_ab_idle"}, busy_o[d], 0);
                return;
            end
            if (poke) start_v[d] = 1'($urandom % 2);
            tick();
        end
        start_v[d] = 1'b0;
        chk({tag, "_done"}, done_o[d], 1);
        chk({tag, "_d_busy"}, busy_o[d], 0);
        chk({tag, "_d_vv"}, vv_o[d], 0);
        chk({tag, "_d_vec"}, vec_o[d], 15);
        chk({tag, "_tt"}, tt_o[d], want_tt);
        chk({tag, "_ones"}, ones_o[d], want_ones);
`ifdef TT_SWEEP_COMPARE_EN
        chk({tag, "_mm"}, mm_o[d], want_mm);
        chk({tag, "_fe"}, fe_o[d], want_fe);
`endif
        if (poke) begin
            start_v[d] = 1'b1;
            abort_v[d] = 1'b1;
        end
        tick();
        start_v[d] = 1'b0;
        abort_v[d] = 1'b0;
        chk({tag, "_post_done"}, done_o[d], 0);
        chk({tag, "_post_busy"}, busy_o[d], 0);
        chk({tag, "_hold_tt"}, tt_o[d], want_tt);
        chk({tag, "_hold_ones"}, ones_o[d], want_ones);
    endtask

    initial begin
        logic [15:0] f2;
        logic [15:0] fn;
        logic [15:0] ex;
        int          d;
        int          ab;
        int          k;
        f2  = f2_table();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
            fn_v[i]    = 16'h0;
            exp_v[i]   = 16'h0;
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_tt", tt_o[i], 0);
            chk("rst_ones", ones_o[i], 0);
            chk("rst_vec", vec_o[i], 0);
            chk("rst_busy", busy_o[i], 0);
            chk("rst_vv", vv_o[i], 0);
            chk("rst_done", done_o[i], 0);
        end

        sweep(0, f2, f2, 0, 1'b0, "t1");
        chk("t1_tt_3fa2", tt_o[0], 32'h3FA2);
        chk("t1_ones_9", ones_o[0], 9);

        sweep(0, 16'hFFFF, 16'hFFFF, 0, 1'b0, "t2_ones");
        sweep(0, 16'h0000, 16'h0000, 0, 1'b0, "t2_zero");

        sweep(1, f2, f2, 0, 1'b0, "t3_s0");
        chk("t3_s0_tt", tt_o[1], 32'h3FA2);
        sweep(2, f2, f2, 0, 1'b0, "t3_s3");
        chk("t3_s3_tt", tt_o[2], 32'h3FA2);

        sweep(0, f2, f2, 12, 1'b1, "t4_abort");
        chk("t4_tt_2", tt_o[0], 32'h0002);
        chk("t4_ones_1", ones_o[0], 1);
        sweep(0, f2, f2, 0, 1'b1, "t4_poke");

        fn_v[0]    = f2;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        k = 0;
        while (vec_o[0] != 4'd9 && k < 100) begin
            tick();
            k++;
        end
        chk("t5_reach_vec9", vec_o[0], 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_tt", tt_o[0], 0);
        chk("t5_rst_ones", ones_o[0], 0);
        chk("t5_rst_vec", vec_o[0], 0);
        chk("t5_rst_busy", busy_o[0], 0);
        chk("t5_rst_vv", vv_o[0], 0);
        chk("t5_rst_done", done_o[0], 0);
        tick();
        chk("t5_rst_nodone", done_o[0], 0);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk("t5_sa_busy", busy_o[0], 0);
        chk("t5_sa_vv", vv_o[0], 0);
        tick();
        chk("t5_sa_busy2", busy_o[0], 0);

        sweep(0, f2, 16'h3FA0, 0, 1'b0, "t6_cmp");
        sweep(0, f2, 16'h3FA2, 0, 1'b0, "t6_match");

        for (int it = 0; it < 24; it++) begin
            d  = $urandom_range(0, 2);
            fn = 16'($urandom);
            ex = fn;
            if ($urandom % 2 == 1) ex = ex ^ (16'd1 << $urandom_range(0, 15));
            ab = ($urandom % 2 == 1) ? $urandom_range(1, 16 * (settle_of(d) + 1)) : 0;
            sweep(d, fn, ex, ab, 1'($urandom % 2), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
